// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmit FSM states and
// small helpers used by both the transmit and receive paths.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BAUD_DIV = 434;  // 50 MHz / 115200

    // Transmit FSM states, in frame order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Parity bit for a byte: even parity makes the total count of ones
    // (data + parity) even, odd parity makes it odd.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 odd);
        return odd ? ~^data : ^data;
    endfunction

    // Total frame length in bit periods (start + data + parity + stop).
    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 1 + DATA_BITS + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts system clocks 0..BAUD_DIV-1 and pulses bit_tick on
// the last count of every bit period. A clear restarts the period so the
// first tick lands exactly BAUD_DIV cycles after the clear is released.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV  // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int                CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Tick on the final count of the bit period; the counter wraps there.
    assign bit_tick = (cnt_q == CNT_LAST);

    // Bit-period counter with synchronous clear and wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter: one start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Byte intake is a valid/ready handshake accepted only in
// IDLE; the serial line is driven from a register so it never glitches.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,  // clocks per bit, >= 2
    parameter int PARITY_EN  = 0,                 // 1: insert parity bit
    parameter int PARITY_ODD = 0,                 // 1: odd, 0: even parity
    parameter int STOP_BITS  = 1                  // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_SEL   = (PARITY_ODD != 0);

    tx_state_e             state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;    // data bit / stop bit index
    logic                  par_q,   par_d;
    logic                  pin_q,   pin_d;
    logic                  done_c;
    logic                  accept;
    logic                  bit_tick;
    logic                  baud_clear;

    assign tx_ready   = (state_q == IDLE) && rst_n;
    assign accept     = tx_valid && tx_ready;
    assign tx_busy    = (state_q != IDLE);
    assign tx_pin_out = pin_q;
    assign tx_done    = done_c && rst_n;

    // Holding the divider in clear while idle means every frame's first
    // bit period starts from count 0 on the cycle after acceptance.
    assign baud_clear = (state_q == IDLE);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    // State, shift register, bit index, parity and line registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
        end
    end

    // Next-state logic; pin_d is the line level for the cycle after the
    // edge, so each transition also selects the level of the next bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        pin_d   = pin_q;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                pin_d = 1'b1;
                idx_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = calc_parity(tx_data, ODD_SEL);
                    pin_d   = 1'b0;
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    pin_d   = shift_q[0];
                end
            end

            DATA: begin
                if (bit_tick) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            pin_d   = par_q;
                        end else begin
                            state_d = STOP;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        pin_d   = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                    pin_d   = 1'b1;
                end
            end

            STOP: begin
                pin_d = 1'b1;
                if (bit_tick) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_c  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                pin_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module. Four instances with BAUD_DIV=4 cover
// the plain frame, even parity, odd parity and two stop bits. Each frame is
// captured cycle by cycle (cycle 1 = first start-bit cycle) on the falling
// edge and compared against hand-derived values.
module tb_uart_tx_module;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic [3:0] ready, pin, busy, done;

    int checks = 0;
    int errors = 0;

    logic cap_pin   [0:127];
    logic cap_done  [0:127];
    logic cap_busy  [0:127];
    logic cap_ready [0:127];

    always #5 clk = ~clk;

    uart_tx_module #(.BAUD_DIV(4)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_pin_out(pin[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_module #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_pin_out(pin[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_module #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_pin_out(pin[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_module #(.BAUD_DIV(4), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_pin_out(pin[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    // Expected line level in frame cycle k (1-based) with 4 clocks per bit.
    function automatic logic exp_line(input logic [7:0] b, input int pe,
                                      input logic odd, input int k);
        int slot;
        slot = (k - 1) / 4;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (pe != 0 && slot == 9) return odd ? ~^b : ^b;
        return 1'b1;
    endfunction

    // Recover a byte by sampling mid-bit from a frame starting at cycle s.
    function automatic logic [7:0] decode(input int s);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = cap_pin[s + 4*(j+1) + 2];
        return b;
    endfunction

    // Present a byte on instance i; it is accepted at the next rising edge.
    task automatic offer(input int i, input logic [7:0] b);
        @(negedge clk);
        checks++;
        if (ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL offer_ready[%0d]: got %b want 1", i, ready[i]);
        end
        valid[i] = 1'b1;
        data[i]  = b;
    endtask

    // Capture cycles 1..n after acceptance; data is swapped to nd in
    // cycle 1 and valid dropped in cycle drop.
    task automatic capture(input int i, input int n, input logic [7:0] nd,
                           input int drop);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap_pin[k]   = pin[i];
            cap_done[k]  = done[i];
            cap_busy[k]  = busy[i];
            cap_ready[k] = ready[i];
            if (k == 1) data[i] = nd;
            if (k == drop) valid[i] = 1'b0;
        end
    endtask

    // Compare a captured frame against the model and the done/busy rules.
    task automatic check_frame(input string nm, input logic [7:0] b,
                               input int pe, input logic odd, input int len);
        int bad, busy_n, done_at, done_n;
        bad = 0; busy_n = 0; done_at = 0; done_n = 0;
        for (int k = 1; k <= len; k++) begin
            if (cap_pin[k] !== exp_line(b, pe, odd, k)) bad++;
            if (cap_busy[k] === 1'b1) busy_n++;
            if (cap_done[k] === 1'b1) begin done_n++; done_at = k; end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_wave: %0d wrong line cycles, want 0", nm, bad);
        end
        checks++;
        if (busy_n != len) begin
            errors++;
            $display("FAIL %s_busy: busy %0d cycles, want %0d", nm, busy_n, len);
        end
        checks++;
        if (done_n != 1 || done_at != len) begin
            errors++;
            $display("FAIL %s_done: %0d pulses last at %0d, want 1 at %0d",
                     nm, done_n, done_at, len);
        end
        checks++;
        if (decode(1) !== b) begin
            errors++;
            $display("FAIL %s_decode: got %h want %h", nm, decode(1), b);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        valid = 4'hF;
        for (int i = 0; i < 4; i++) data[i] = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 4'h0) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", ready);
        end
        checks++;
        if (pin !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
            errors++;
            $display("FAIL reset_outs: pin %b busy %b done %b want 1111 0000 0000",
                     pin, busy, done);
        end
        valid = 4'h0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 4'hF || pin !== 4'hF) begin
            errors++;
            $display("FAIL reset_release: ready %b pin %b want 1111 1111", ready, pin);
        end
    endtask

    task automatic test_basic;
        offer(0, 8'h55);
        capture(0, 41, 8'h55, 1);
        check_frame("basic", 8'h55, 0, 1'b0, 40);
        // 0x55 LSB first: start 0 then 1,0,1,0,1,0,1,0 then stop 1
        checks++;
        if (cap_pin[4] !== 1'b0 || cap_pin[5] !== 1'b1 || cap_pin[9] !== 1'b0 ||
            cap_pin[36] !== 1'b0 || cap_pin[37] !== 1'b1) begin
            errors++;
            $display("FAIL basic_bits: c4 %b c5 %b c9 %b c36 %b c37 %b want 0 1 0 0 1",
                     cap_pin[4], cap_pin[5], cap_pin[9], cap_pin[36], cap_pin[37]);
        end
        checks++;
        if (cap_ready[41] !== 1'b1 || cap_busy[41] !== 1'b0 || cap_pin[41] !== 1'b1) begin
            errors++;
            $display("FAIL basic_after: ready %b busy %b pin %b want 1 0 1",
                     cap_ready[41], cap_busy[41], cap_pin[41]);
        end
    endtask

    task automatic test_parity_even;
        offer(1, 8'h07);
        capture(1, 45, 8'h07, 1);
        check_frame("par_even", 8'h07, 1, 1'b0, 44);
        checks++;
        if ({cap_pin[37], cap_pin[38], cap_pin[39], cap_pin[40]} !== 4'b1111) begin
            errors++;
            $display("FAIL par_even_bit: got %b%b%b%b want 1111",
                     cap_pin[37], cap_pin[38], cap_pin[39], cap_pin[40]);
        end
    endtask

    task automatic test_parity_odd;
        offer(2, 8'h07);
        capture(2, 45, 8'h07, 1);
        check_frame("par_odd", 8'h07, 1, 1'b1, 44);
        checks++;
        if ({cap_pin[37], cap_pin[38], cap_pin[39], cap_pin[40]} !== 4'b0000) begin
            errors++;
            $display("FAIL par_odd_bit: got %b%b%b%b want 0000",
                     cap_pin[37], cap_pin[38], cap_pin[39], cap_pin[40]);
        end
    endtask

    task automatic test_back_to_back;
        int dn;
        offer(0, 8'hA5);
        capture(0, 82, 8'h3C, 42);
        checks++;
        if (cap_done[40] !== 1'b1 || cap_pin[41] !== 1'b1 || cap_ready[41] !== 1'b1 ||
            cap_pin[42] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: done40 %b pin41 %b ready41 %b pin42 %b want 1 1 1 0",
                     cap_done[40], cap_pin[41], cap_ready[41], cap_pin[42]);
        end
        checks++;
        if (decode(1) !== 8'hA5) begin
            errors++; $display("FAIL b2b_first: got %h want a5", decode(1));
        end
        checks++;
        if (decode(42) !== 8'h3C) begin
            errors++; $display("FAIL b2b_second: got %h want 3c", decode(42));
        end
        dn = 0;
        for (int k = 1; k <= 82; k++) if (cap_done[k] === 1'b1) dn++;
        checks++;
        if (dn != 2 || cap_done[81] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: %0d pulses, done81 %b want 2 and 1", dn, cap_done[81]);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        offer(0, 8'hFF);
        capture(0, 18, 8'hFF, 1);   // cycle 18 lies in data bit 3 (cycles 17-20)
        rst_n = 1'b0;
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready_comb: got %b want 0", ready[0]);
        end
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) dn++;
            checks++;
            if (pin[0] !== 1'b1 || ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_hold: pin %b ready %b busy %b want 1 0 0",
                         pin[0], ready[0], busy[0]);
            end
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done[0] === 1'b1) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++; $display("FAIL rstmid_nodone: %0d pulses want 0", dn);
        end
        offer(0, 8'h81);
        capture(0, 41, 8'h81, 1);
        check_frame("rstmid_next", 8'h81, 0, 1'b0, 40);
    endtask

    task automatic test_stability;
        offer(0, 8'h3C);
        capture(0, 41, 8'hC3, 1);
        check_frame("stable", 8'h3C, 0, 1'b0, 40);
    endtask

    task automatic test_two_stop;
        int rdy_n;
        offer(3, 8'h5A);
        capture(3, 45, 8'h5A, 1);
        check_frame("stop2", 8'h5A, 0, 1'b0, 44);
        rdy_n = 0;
        for (int k = 1; k <= 44; k++) if (cap_ready[k] !== 1'b0) rdy_n++;
        checks++;
        if (rdy_n != 0 || cap_ready[45] !== 1'b1) begin
            errors++;
            $display("FAIL stop2_ready: %0d ready cycles in frame, ready45 %b want 0 and 1",
                     rdy_n, cap_ready[45]);
        end
        checks++;
        if (cap_pin[37] !== 1'b1 || cap_pin[44] !== 1'b1 || cap_pin[36] !== 1'b0) begin
            errors++;
            $display("FAIL stop2_line: c36 %b c37 %b c44 %b want 0 1 1",
                     cap_pin[36], cap_pin[37], cap_pin[44]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_even();
        test_parity_odd();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        test_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
